data_sram_ctrl: RTL and testbench

DATA_SRAM_CTRL -- requirements
Module: data_sram_ctrl

---
 rtl/data_sram_ctrl_if.sv | 23 ++
 rtl/data_sram_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_data_sram_ctrl.sv | 360 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/data_sram_ctrl_if.sv
// SRAM-like data bus between the MEM-stage access controller (master)
// and the data memory or bus bridge (slave).
interface data_sram_ctrl_if;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [3:0]  data_wstrb;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;

  modport master (
    output data_req, data_wr, data_size, data_addr, data_wdata, data_wstrb,
    input  data_addr_ok, data_data_ok, data_rdata
  );

  modport slave (
    input  data_req, data_wr, data_size, data_addr, data_wdata, data_wstrb,
    output data_addr_ok, data_data_ok, data_rdata
  );
endinterface

// File: rtl/data_sram_ctrl.sv
// MEM-stage data access controller: checks alignment, issues one load or
// store at a time on the SRAM-like bus, extends load data, and lets a
// writeback flush cancel an access without abandoning the bus handshake.
module data_sram_ctrl (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   mem_valid,
  input  logic [4:0]             load_type,
  input  logic [2:0]             store_type,
  input  logic [31:0]            mem_addr,
  input  logic [31:0]            mem_wdata,
  input  logic                   flush,
  data_sram_ctrl_if.master       bus,
  output logic                   mem_stall,
  output logic                   done,
  output logic [31:0]            load_result,
  output logic                   adel,
  output logic                   ades,
  output logic [31:0]            badvaddr
);

  typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2, DONE = 2'd3} state_t;

  state_t      state_r, state_s;
  logic        cancel_r, cancel_s;
  logic        rdata_en_s;
  logic [31:0] addr_r, wdata_r, rdata_r;
  logic [1:0]  size_r;
  logic        wr_r;
  logic [3:0]  wstrb_r;
  logic [4:0]  load_type_r;

  logic        is_store_s, is_load_s, access_s, load_mis_s, store_mis_s, accept_s;
  logic [1:0]  size_s;
  logic [3:0]  wstrb_s;
  logic [31:0] wdata_s;
  logic [7:0]  byte_s;
  logic [15:0] half_s;
  logic [31:0] ext_s;

  // Decode the incoming access: class, alignment faults, acceptance and bus fields.
  always_comb begin
    is_store_s  = |store_type;
    is_load_s   = ~is_store_s & (|load_type);
    access_s    = mem_valid & (is_store_s | is_load_s);
    load_mis_s  = (mem_addr[0] & (load_type[2] | load_type[3])) |
                  ((mem_addr[1:0] != 2'b00) & load_type[4]);
    store_mis_s = (mem_addr[0] & store_type[1]) |
                  ((mem_addr[1:0] != 2'b00) & store_type[2]);
    adel        = (state_r == IDLE) & access_s & is_load_s & load_mis_s;
    ades        = (state_r == IDLE) & access_s & is_store_s & store_mis_s;
    badvaddr    = mem_addr;
    accept_s    = (state_r == IDLE) & access_s & ~(is_load_s & load_mis_s) &
                  ~(is_store_s & store_mis_s) & ~flush;
    if (is_store_s) begin
      if (store_type[2]) begin
        size_s  = 2'd2;
        wstrb_s = 4'b1111;
        wdata_s = mem_wdata;
      end else if (store_type[1]) begin
        size_s  = 2'd1;
        wstrb_s = 4'b0011 << mem_addr[1:0];
        wdata_s = {2{mem_wdata[15:0]}};
      end else begin
        size_s  = 2'd0;
        wstrb_s = 4'b0001 << mem_addr[1:0];
        wdata_s = {4{mem_wdata[7:0]}};
      end
    end else begin
      wstrb_s = 4'b0000;
      wdata_s = 32'd0;
      if (load_type[4]) begin
        size_s = 2'd2;
      end else if (load_type[2] | load_type[3]) begin
        size_s = 2'd1;
      end else begin
        size_s = 2'd0;
      end
    end
  end

  // State and cancel flag registers.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_r  <= IDLE;
      cancel_r <= 1'b0;
    end else begin
      state_r  <= state_s;
      cancel_r <= cancel_s;
    end
  end

  // Next state, cancel tracking and handshake outputs; reset forces outputs quiet.
  always_comb begin
    state_s    = state_r;
    cancel_s   = cancel_r;
    rdata_en_s = 1'b0;
    case (state_r)
      IDLE: begin
        cancel_s = 1'b0;
        if (accept_s) begin
          state_s = REQ;
        end else begin
          state_s = IDLE;
        end
      end
      REQ: begin
        cancel_s = cancel_r | flush;
        if (bus.data_addr_ok) begin
          if (bus.data_data_ok) begin
            rdata_en_s = 1'b1;
            if (cancel_r | flush) begin
              state_s  = IDLE;
              cancel_s = 1'b0;
            end else begin
              state_s = DONE;
            end
          end else begin
            state_s = WAIT;
          end
        end else begin
          state_s = REQ;
        end
      end
      WAIT: begin
        cancel_s = cancel_r | flush;
        if (bus.data_data_ok) begin
          rdata_en_s = 1'b1;
          if (cancel_r | flush) begin
            state_s  = IDLE;
            cancel_s = 1'b0;
          end else begin
            state_s = DONE;
          end
        end else begin
          state_s = WAIT;
        end
      end
      DONE: begin
        state_s  = IDLE;
        cancel_s = 1'b0;
      end
      default: begin
        state_s  = IDLE;
        cancel_s = 1'b0;
      end
    endcase
    bus.data_req    = resetn & (state_r == REQ);
    bus.data_wr     = wr_r;
    bus.data_size   = size_r;
    bus.data_addr   = addr_r;
    bus.data_wdata  = wdata_r;
    bus.data_wstrb  = resetn ? wstrb_r : 4'b0000;
    mem_stall       = resetn & (accept_s | (state_r == REQ) | (state_r == WAIT));
    done            = resetn & (state_r == DONE) & ~flush;
    load_result     = resetn ? ext_s : 32'd0;
  end

  // Latch the accepted access and the returned read word.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      addr_r      <= 32'd0;
      wdata_r     <= 32'd0;
      rdata_r     <= 32'd0;
      size_r      <= 2'd0;
      wr_r        <= 1'b0;
      wstrb_r     <= 4'b0000;
      load_type_r <= 5'd0;
    end else begin
      if (accept_s) begin
        addr_r      <= mem_addr;
        wdata_r     <= wdata_s;
        size_r      <= size_s;
        wr_r        <= is_store_s;
        wstrb_r     <= wstrb_s;
        load_type_r <= is_store_s ? 5'd0 : load_type;
      end
      if (rdata_en_s) begin
        rdata_r <= bus.data_rdata;
      end
    end
  end

  // Pick the addressed byte/half from the read word and extend it.
  always_comb begin
    case (addr_r[1:0])
      2'd0:    byte_s = rdata_r[7:0];
      2'd1:    byte_s = rdata_r[15:8];
      2'd2:    byte_s = rdata_r[23:16];
      2'd3:    byte_s = rdata_r[31:24];
      default: byte_s = 8'd0;
    endcase
    half_s = addr_r[1] ? rdata_r[31:16] : rdata_r[15:0];
    if (load_type_r[0]) begin
      ext_s = {{24{byte_s[7]}}, byte_s};
    end else if (load_type_r[1]) begin
      ext_s = {24'd0, byte_s};
    end else if (load_type_r[2]) begin
      ext_s = {{16{half_s[15]}}, half_s};
    end else if (load_type_r[3]) begin
      ext_s = {16'd0, half_s};
    end else if (load_type_r[4]) begin
      ext_s = rdata_r;
    end else begin
      ext_s = 32'd0;
    end
  end

endmodule

// File: tb/tb_data_sram_ctrl.sv
// Scoreboard bench for data_sram_ctrl: a bus responder with programmable
// addr_ok/data_ok latency, per-access expectations queued at issue time and
// checked when the DUT presents its request and its done pulse.
module tb_data_sram_ctrl;

  localparam int LB = 0, LBU = 1, LH = 2, LHU = 3, LW = 4, SB = 5, SH = 6, SW = 7;

  logic        clk = 1'b0;
  logic        resetn, mem_valid, flush;
  logic [4:0]  load_type;
  logic [2:0]  store_type;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_stall, done, adel, ades;
  logic [31:0] load_result, badvaddr;

  data_sram_ctrl_if bus ();

  data_sram_ctrl dut (
    .clk(clk), .resetn(resetn), .mem_valid(mem_valid), .load_type(load_type),
    .store_type(store_type), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .flush(flush), .bus(bus.master), .mem_stall(mem_stall), .done(done),
    .load_result(load_result), .adel(adel), .ades(ades), .badvaddr(badvaddr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
  } bus_exp_t;

  bus_exp_t    bus_q[$];
  logic [31:0] res_q[$];
  bus_exp_t    mon_e;
  int          n_checks = 0;
  int          n_fail = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model of the access encoding
  function automatic logic [1:0] exp_size(input int op);
    case (op)
      LB, LBU, SB: exp_size = 2'd0;
      LH, LHU, SH: exp_size = 2'd1;
      default:     exp_size = 2'd2;
    endcase
  endfunction

  function automatic logic [3:0] exp_wstrb(input int op, input logic [31:0] a);
    logic [3:0] s;
    s = 4'b0000;
    if (op == SW) s = 4'b1111;
    else if (op == SH) s = a[1] ? 4'b1100 : 4'b0011;
    else if (op == SB) s[a[1:0]] = 1'b1;
    return s;
  endfunction

  function automatic logic [31:0] exp_wdata(input int op, input logic [31:0] w);
    if (op == SB) return {w[7:0], w[7:0], w[7:0], w[7:0]};
    if (op == SH) return {w[15:0], w[15:0]};
    return w;
  endfunction

  function automatic logic [31:0] exp_res(input int op, input logic [31:0] a, input logic [31:0] r);
    logic [31:0] sh;
    logic [7:0]  b;
    logic [15:0] h;
    sh = r >> (8 * a[1:0]);
    b  = sh[7:0];
    h  = a[1] ? r[31:16] : r[15:0];
    case (op)
      LB:      return {{24{b[7]}}, b};
      LBU:     return {24'd0, b};
      LH:      return {{16{h[15]}}, h};
      LHU:     return {16'd0, h};
      LW:      return r;
      default: return 32'd0;
    endcase
  endfunction

  // Bus responder
  int          addr_dly = 0, data_dly = 0;
  bit          same_cyc = 1'b0;
  logic [31:0] rd_val = 32'd0;
  int          rcnt = 0, dcnt = 0;
  bit          pend = 1'b0, hs_a = 1'b0, hs_d = 1'b0, rl = 1'b0;

  initial begin
    bus.data_addr_ok = 1'b0;
    bus.data_data_ok = 1'b0;
    bus.data_rdata   = 32'd0;
    forever begin
      @(negedge clk);
      hs_a = bus.data_req & bus.data_addr_ok;
      hs_d = bus.data_data_ok;
      rl   = resetn;
      @(posedge clk);
      #1;
      if (!rl) begin
        pend = 1'b0;
        rcnt = 0;
      end else begin
        if (hs_a && !hs_d) begin
          pend = 1'b1;
          dcnt = 0;
        end
        if (hs_d) pend = 1'b0;
      end
      if (bus.data_req) begin
        bus.data_addr_ok = (rcnt >= addr_dly);
        rcnt++;
      end else begin
        bus.data_addr_ok = 1'b0;
        rcnt = 0;
      end
      if (pend) begin
        bus.data_data_ok = (dcnt >= data_dly);
        dcnt++;
      end else begin
        bus.data_data_ok = bus.data_addr_ok & same_cyc;
      end
      bus.data_rdata = rd_val;
    end
  end

  // Scoreboard monitor: request fields while requesting, load result on done
  always @(negedge clk) begin
    if (resetn) begin
      if (bus.data_req) begin
        if (bus_q.size() == 0) begin
          check_val("req_unexp", {31'd0, bus.data_req}, 32'd0);
        end else begin
          mon_e = bus_q[0];
          check_val("bus_wr", {31'd0, bus.data_wr}, {31'd0, mon_e.wr});
          check_val("bus_size", {30'd0, bus.data_size}, {30'd0, mon_e.size});
          check_val("bus_addr", bus.data_addr, mon_e.addr);
          check_val("bus_wstrb", {28'd0, bus.data_wstrb}, {28'd0, mon_e.wstrb});
          if (mon_e.wr) check_val("bus_wdata", bus.data_wdata, mon_e.wdata);
          if (bus.data_addr_ok) void'(bus_q.pop_front());
        end
      end
      if (done) begin
        if (res_q.size() == 0) check_val("done_unexp", {31'd0, done}, 32'd0);
        else check_val("load_result", load_result, res_q.pop_front());
      end
    end
  end

  task automatic set_op(input int op, input logic [4:0] extra_lt);
    if (op < 5) begin
      load_type  = 5'b00001 << op;
      store_type = 3'b000;
    end else begin
      load_type  = extra_lt;
      store_type = 3'b001 << (op - 5);
    end
  endtask

  // Present one aligned access for its accept cycle and queue its expectations
  task automatic drive_op(input int op, input logic [31:0] a, input logic [31:0] w,
                          input logic [31:0] r, input int ad, input int dd,
                          input bit same, input bit exp_done, input logic [4:0] extra_lt);
    bus_exp_t e;
    @(posedge clk); #2;
    addr_dly = ad; data_dly = dd; same_cyc = same; rd_val = r;
    set_op(op, extra_lt);
    mem_valid = 1'b1; mem_addr = a; mem_wdata = w;
    e.wr = (op >= SB); e.size = exp_size(op); e.addr = a;
    e.wstrb = exp_wstrb(op, a); e.wdata = exp_wdata(op, w);
    bus_q.push_back(e);
    if (exp_done) res_q.push_back(exp_res(op, a, r));
    @(negedge clk);
    check_val("accept_stall", {31'd0, mem_stall}, 32'd1);
    @(posedge clk); #2;
    mem_valid = 1'b0; load_type = 5'd0; store_type = 3'd0;
  endtask

  task automatic wait_done();
    bit got;
    got = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        break;
      end
    end
    check_val("done_seen", {31'd0, got}, 32'd1);
  endtask

  task automatic wait_bus(input bit want_data);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (want_data ? bus.data_data_ok : (bus.data_req & bus.data_addr_ok)) begin
        got = 1'b1;
        break;
      end
    end
    check_val(want_data ? "data_ok_seen" : "addr_ok_seen", {31'd0, got}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    int          op;
    resetn = 1'b0; mem_valid = 1'b0; flush = 1'b0;
    load_type = 5'd0; store_type = 3'd0; mem_addr = 32'd0; mem_wdata = 32'd0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_val("rst_req", {31'd0, bus.data_req}, 32'd0);
    check_val("rst_stall", {31'd0, mem_stall}, 32'd0);
    check_val("rst_done", {31'd0, done}, 32'd0);
    check_val("rst_lres", load_result, 32'd0);
    check_val("rst_wstrb", {28'd0, bus.data_wstrb}, 32'd0);
    @(posedge clk); #2;
    resetn = 1'b1;

    // lb at 0x1003, addr_ok T+1, data_ok T+2
    drive_op(LB, 32'h0000_1003, 32'd0, 32'h80FF_FF7F, 0, 0, 1'b0, 1'b1, 5'd0);
    @(negedge clk);
    check_val("lb_stall_t1", {31'd0, mem_stall}, 32'd1);
    @(negedge clk);
    check_val("lb_stall_t2", {31'd0, mem_stall}, 32'd1);
    check_val("lb_done_t2", {31'd0, done}, 32'd0);
    @(negedge clk);
    check_val("lb_done_t3", {31'd0, done}, 32'd1);
    check_val("lb_result", load_result, 32'hFFFF_FF80);
    check_val("lb_stall_t3", {31'd0, mem_stall}, 32'd0);

    // sh at 0x2002
    drive_op(SH, 32'h0000_2002, 32'h1234_ABCD, 32'd0, 1, 1, 1'b0, 1'b1, 5'd0);
    @(negedge clk);
    check_val("sh_req", {31'd0, bus.data_req}, 32'd1);
    check_val("sh_wstrb", {28'd0, bus.data_wstrb}, 32'h0000_000C);
    check_val("sh_wdata", bus.data_wdata, 32'hABCD_ABCD);
    check_val("sh_wr", {31'd0, bus.data_wr}, 32'd1);
    check_val("sh_size", {30'd0, bus.data_size}, 32'd1);
    wait_done();

    // Misaligned lw at 0x3002
    @(posedge clk); #2;
    set_op(LW, 5'd0); mem_valid = 1'b1; mem_addr = 32'h0000_3002;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_val("lw_adel", {31'd0, adel}, 32'd1);
      check_val("lw_badv", badvaddr, 32'h0000_3002);
      check_val("lw_stall", {31'd0, mem_stall}, 32'd0);
      check_val("lw_noreq", {31'd0, bus.data_req}, 32'd0);
    end
    // Misaligned sw at 0x5001
    @(posedge clk); #2;
    set_op(SW, 5'd0); mem_addr = 32'h0000_5001;
    @(negedge clk);
    check_val("sw_ades", {31'd0, ades}, 32'd1);
    check_val("sw_adel", {31'd0, adel}, 32'd0);
    check_val("sw_badv", badvaddr, 32'h0000_5001);
    check_val("sw_stall", {31'd0, mem_stall}, 32'd0);
    // Aligned access with flush in IDLE is ignored
    @(posedge clk); #2;
    set_op(LW, 5'd0); mem_addr = 32'h0000_7000; flush = 1'b1;
    @(negedge clk);
    check_val("iflush_stall", {31'd0, mem_stall}, 32'd0);
    @(posedge clk); #2;
    flush = 1'b0; mem_valid = 1'b0; load_type = 5'd0;
    @(negedge clk);
    check_val("iflush_noreq", {31'd0, bus.data_req}, 32'd0);

    // Store wins over a simultaneous (misaligned) load
    drive_op(SB, 32'h0000_3003, 32'h0000_00A5, 32'd0, 0, 1, 1'b0, 1'b1, 5'b10000);
    wait_done();

    // lhu at 0x4000, addr_ok delayed 3 cycles, flush in the first WAIT cycle
    drive_op(LHU, 32'h0000_4000, 32'd0, 32'hDEAD_8001, 3, 2, 1'b0, 1'b0, 5'd0);
    wait_bus(1'b0);
    @(posedge clk); #2;
    flush = 1'b1;
    @(negedge clk);
    check_val("cancel_stall", {31'd0, mem_stall}, 32'd1);
    check_val("cancel_done", {31'd0, done}, 32'd0);
    @(posedge clk); #2;
    flush = 1'b0;
    wait_bus(1'b1);
    @(negedge clk);
    check_val("cancel_idle_stall", {31'd0, mem_stall}, 32'd0);
    check_val("cancel_idle_done", {31'd0, done}, 32'd0);

    // addr_ok and data_ok together: DONE one cycle after REQ
    drive_op(LBU, 32'h0000_1102, 32'd0, 32'h1122_3344, 0, 0, 1'b1, 1'b1, 5'd0);
    @(negedge clk);
    check_val("same_req", {31'd0, bus.data_req}, 32'd1);
    @(negedge clk);
    check_val("same_done", {31'd0, done}, 32'd1);
    check_val("same_lres", load_result, 32'h0000_0022);

    // flush in DONE suppresses the done pulse
    drive_op(LH, 32'h0000_1202, 32'd0, 32'h8001_7FFF, 0, 0, 1'b0, 1'b0, 5'd0);
    @(posedge clk); #2;
    @(posedge clk); #2;
    flush = 1'b1;
    @(negedge clk);
    check_val("dflush_done", {31'd0, done}, 32'd0);
    check_val("dflush_stall", {31'd0, mem_stall}, 32'd0);
    check_val("dflush_lres", load_result, 32'hFFFF_8001);
    @(posedge clk); #2;
    flush = 1'b0;
    @(negedge clk);
    check_val("dflush_idle", {31'd0, bus.data_req | mem_stall | done}, 32'd0);

    // Reset while in WAIT
    drive_op(LW, 32'h0000_6000, 32'd0, 32'h5555_AAAA, 0, 10, 1'b0, 1'b0, 5'd0);
    @(posedge clk); #2;
    resetn = 1'b0;
    @(negedge clk);
    check_val("wrst_stall", {31'd0, mem_stall}, 32'd0);
    check_val("wrst_req", {31'd0, bus.data_req}, 32'd0);
    @(posedge clk); #2;
    resetn = 1'b1;
    @(negedge clk);
    check_val("wrst_idle_req", {31'd0, bus.data_req}, 32'd0);
    check_val("wrst_idle_stall", {31'd0, mem_stall}, 32'd0);
    check_val("wrst_idle_done", {31'd0, done}, 32'd0);
    res_q.delete();

    // Random aligned traffic with random bus latency
    for (int k = 0; k < 24; k++) begin
      op = $urandom_range(0, 7);
      a  = $urandom;
      if (op == LH || op == LHU || op == SH) a[0] = 1'b0;
      if (op == LW || op == SW) a[1:0] = 2'b00;
      drive_op(op, a, $urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 3),
               1'($urandom_range(0, 1)), 1'b1, 5'd0);
      wait_done();
    end

    repeat (2) @(posedge clk);
    check_val("bus_q_empty", bus_q.size(), 32'd0);
    check_val("res_q_empty", res_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
